ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
- Parametrised successor to the single-request fetch stage.
- Keeps up to MAX_OUT instruction requests in flight on the inst SRAM-like bus.
- Buffers returned instructions in a DEPTH-entry queue feeding pre-decode.
- Redirects (exception, ertn, branch, prediction) flush the queue and drop stale responses from the old path, so pre-decode only ever sees in-order, correct-path instructions or a fetch-exception entry.

Parameters:
- DEPTH, 4, instruction queue entries (power of 2, ≥2).
- MAX_OUT, 2, maximum outstanding requests (power of 2, ≥1, ≤DEPTH).
- RESET_PC, 32'h1c00_0000, first fetch address after reset.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- redirect_valid  in  1  flush and restart fetch; caller resolves priority
- redirect_pc  in  32  new fetch address
- fetch_vaddr  out  32  current PC, to the translation logic
- xlat_paddr  in  32  translated address of fetch_vaddr, combinational
- xlat_ex  in  1  translation fault on fetch_vaddr
- xlat_ecode  in  8  fault code when xlat_ex=1
- inst_sram_req  out  1  request
- inst_sram_addr  out  32  = xlat_paddr
- inst_sram_addr_ok  in  1  request accepted
- inst_sram_data_ok  in  1  response valid
- inst_sram_rdata  in  32  response instruction
- out_valid  out  1  entry available to pre-decode
- out_ready  in  1  pre-decode accepts
- out_pc  out  32  entry PC
- out_inst  out  32  entry instruction (0 for exception entries)
- out_ex  out  1  entry is a fetch exception
- out_ecode  out  8  exception code

Behaviour:
- Reset (async, rstn=0): pc=RESET_PC, state=RUN, inflight=0, drop_cnt=0, queue empty; out_valid=0, inst_sram_req=0.
- Counters: inflight and drop_cnt are each clog2(MAX_OUT)+1 bits. Invariant: drop_cnt ≤ inflight ≤ MAX_OUT.
- Occupancy: occ = queue count + (inflight − drop_cnt). Queue slots are reserved at issue, so the queue never overflows.
- Address check: adef = (pc[1:0]!=0). fault = adef | xlat_ex.
- State RUN, no fault: inst_sram_req = !redirect_valid & inflight<MAX_OUT & occ<DEPTH.
  - On req & addr_ok: push pc into the tag FIFO, inflight++, pc<=pc+4. The 32-bit wrap is ignored.
- State RUN, fault: inst_sram_req=0.
  - Wait until inflight==0 and the queue has a free slot, then push an exception entry and go to HALT.
  - Exception entry: {pc, inst=0, ex=1, ecode}. ecode = ECODE_ADEF when adef, else xlat_ecode; adef wins.
- State HALT: no requests. Leave only on redirect_valid.
- Response (data_ok): inflight--.
  - If drop_cnt>0: drop_cnt-- and discard the data. The tag was already cleared at redirect.
  - Else: pop the tag FIFO and push {tag, rdata, 0, 0} into the queue.
- Output: out_* show the queue head. out_valid = !empty. Pop on out_valid & out_ready.
  - A push to a full queue cannot occur; assert it in simulation.
- Redirect (takes priority over everything in that cycle):
  - pc<=redirect_pc, state<=RUN.
  - Queue and tag FIFO cleared; out_valid=0 the next cycle.
  - No request is issued in the redirect cycle.
  - drop_cnt <= inflight − data_ok. A response arriving in the redirect cycle is itself discarded.
  - inflight <= inflight − data_ok.
- Redirect while drop_cnt>0: drops accumulate correctly because drop_cnt is reloaded from the live inflight count.
- Simultaneous push and pop on a full queue is legal. occ accounting makes push-on-full unreachable.
- Latency: request issue to out_valid is 1 cycle after data_ok (registered queue), without the bypass option.

Optional Feature:
- Macro IFQ_BYPASS_EN.
- Defined: when the queue is empty, data_ok is not dropped, and out_ready=1, the response goes combinationally to out_* in the same cycle and is not written into the queue. out_valid=1 that cycle. Exception entries never bypass.
- Undefined: every entry is registered in the queue first, giving a 1-cycle minimum latency.

Decomposition:
- Package fetch_pkg:
  - ECODE_ADEF=8'h08.
  - Entry struct/width: pc 32 + inst 32 + ex 1 + ecode 8 = 73 bits.
  - Localparam functions for counter widths.
- Sub-module sync_fifo #(WIDTH,DEPTH):
  - Synchronous flush input; count, full and empty outputs.
  - Instantiated twice: tag FIFO (32×MAX_OUT) and instruction queue (73×DEPTH).

Test Plan:
- Streaming fetch (addr_ok always 1, data_ok 1 cycle later, out_ready=1) from reset → out_pc 1c000000, 1c000004, 1c000008… in order. inflight never exceeds MAX_OUT=2.
- out_ready=0 with DEPTH=4 → exactly 4 requests accepted, then inst_sram_req=0. Raise out_ready → resumes; 4 entries drain in order.
- Two requests in flight, redirect_pc=1c001000 → both old responses discarded (drop_cnt 2→0). First out_pc=1c001000.
- Redirect in the same cycle as data_ok with inflight=2 → drop_cnt=1. Only the second old response is dropped; no stale entry appears.
- redirect_pc=1c000002 → no SRAM request; one entry with out_ex=1, out_ecode=8'h08, out_pc=1c000002. Block stays HALT until the next redirect.
- xlat_ex=1, xlat_ecode=8'h3f while 1 request is outstanding → that response is delivered first, then the exception entry with ecode 8'h3f. Async rstn pulse mid-stream → out_valid=0 and pc=RESET_PC immediately.

Source files
------------

// File: rtl/ifetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Optional build macro: IFQ_BYPASS_EN (see rtl/ifetch_queue.sv).
package fetch_pkg;

    localparam logic [7:0] ECODE_ADEF = 8'h08;
    localparam int         ENTRY_W    = 73;

    // One pre-decode entry: pc 32 + inst 32 + ex 1 + ecode 8.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ex;
        logic [7:0]  ecode;
    } entry_t;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

    // Width of a counter that must hold the values 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

    // Width of a pointer indexing n slots (at least one bit).
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Instruction SRAM-like bus plus the pre-decode handshake of the fetch queue.
// master = fetch queue, slave = memory system and pre-decode stage.
interface ifetch_queue_if;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ex;
    logic [7:0]  out_ecode;

    modport master (
        output inst_sram_req, inst_sram_addr, out_valid, out_pc, out_inst, out_ex, out_ecode,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, out_ready
    );

    modport slave (
        input  inst_sram_req, inst_sram_addr, out_valid, out_pc, out_inst, out_ex, out_ecode,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, out_ready
    );
endinterface

// File: rtl/ifetch_queue_fifo.sv
// Synchronous FIFO with flush; used for the tag FIFO and the instruction queue.
module sync_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      flush,
    input  logic                      push,
    input  logic [WIDTH-1:0]          din,
    input  logic                      pop,
    output logic [WIDTH-1:0]          dout,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      full,
    output logic                      empty
);
    localparam int AW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

    // Slot reservation upstream must make a write into a full FIFO impossible.
    assert property (@(posedge clk) disable iff (!rstn) !(push && full && !pop && !flush));

endmodule

// File: rtl/ifetch_queue.sv
// Multi-outstanding instruction fetch with an in-order queue to pre-decode.
// Redirects flush the queue and discard responses still owed on the old path.
// Build macro IFQ_BYPASS_EN: forward a response straight to out_* when the queue is empty.
module ifetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           redirect_valid,
    input  logic [31:0]    redirect_pc,
    output logic [31:0]    fetch_vaddr,
    input  logic [31:0]    xlat_paddr,
    input  logic           xlat_ex,
    input  logic [7:0]     xlat_ecode,
    ifetch_queue_if.master bus
);
    localparam int CW = cnt_w(MAX_OUT);
    localparam int QW = cnt_w(DEPTH);
    localparam int OW = QW + 1;

    fetch_state_t   state;
    fetch_state_t   state_next;
    logic [31:0]    pc;
    logic [CW-1:0]  inflight;
    logic [CW-1:0]  drop_cnt;
    logic [OW-1:0]  occ;
    logic           adef;
    logic           fault;
    logic           req;
    logic           fire;
    logic           ex_push;
    logic           data_ok;
    logic           resp_keep;
    logic           bypass;
    entry_t         resp_entry;
    entry_t         ex_entry;
    entry_t         q_din;
    logic [ENTRY_W-1:0] q_dout;
    entry_t         head;
    entry_t         out_entry;
    logic           q_push;
    logic           q_pop;
    logic [QW-1:0]  q_count;
    logic           q_full;
    logic           q_empty;
    logic [31:0]    tag_dout;
    logic [CW-1:0]  tag_count;
    logic           tag_full;
    logic           tag_empty;

    assign adef      = (pc[1:0] != 2'b00);
    assign fault     = adef | xlat_ex;
    assign occ       = OW'(q_count) + OW'(inflight - drop_cnt);
    assign fire      = req & bus.inst_sram_addr_ok;
    assign data_ok   = bus.inst_sram_data_ok;
    assign resp_keep = data_ok & (drop_cnt == '0) & ~redirect_valid;

`ifdef IFQ_BYPASS_EN
    assign bypass = q_empty & resp_keep & bus.out_ready;
`else
    assign bypass = 1'b0;
`endif

    assign resp_entry = '{pc: tag_dout, inst: bus.inst_sram_rdata, ex: 1'b0, ecode: 8'h00};
    assign ex_entry   = '{pc: pc, inst: 32'h0, ex: 1'b1, ecode: adef ? ECODE_ADEF : xlat_ecode};
    assign q_din      = ex_push ? ex_entry : resp_entry;
    assign q_push     = ex_push | (resp_keep & ~bypass);
    assign q_pop      = bus.out_ready & ~q_empty;

    // Fetch state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_RUN;
        else       state <= state_next;
    end

    // Request issue, exception insertion and state transitions; redirect overrides all.
    always_comb begin
        state_next = state;
        req        = 1'b0;
        ex_push    = 1'b0;
        case (state)
            ST_RUN: begin
                if (!redirect_valid) begin
                    if (!fault) begin
                        req = rstn && (inflight < CW'(MAX_OUT)) && (occ < OW'(DEPTH));
                    end else if ((inflight == '0) && !q_full) begin
                        ex_push    = 1'b1;
                        state_next = ST_HALT;
                    end
                end
            end
            default: ;
        endcase
        if (redirect_valid) state_next = ST_RUN;
    end

    // PC and outstanding/drop counters; a redirect turns every live request into a drop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc       <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            inflight <= inflight - CW'(data_ok);
            drop_cnt <= inflight - CW'(data_ok);
        end else begin
            if (fire) pc <= pc + 32'd4;
            inflight <= inflight + CW'(fire) - CW'(data_ok);
            if (data_ok && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
        end
    end

    sync_fifo #(.WIDTH(32), .DEPTH(MAX_OUT)) u_tag_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .flush (redirect_valid),
        .push  (fire),
        .din   (pc),
        .pop   (resp_keep),
        .dout  (tag_dout),
        .count (tag_count),
        .full  (tag_full),
        .empty (tag_empty)
    );

    sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_inst_queue (
        .clk   (clk),
        .rstn  (rstn),
        .flush (redirect_valid),
        .push  (q_push),
        .din   (q_din),
        .pop   (q_pop),
        .dout  (q_dout),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    assign head          = q_dout;
    assign out_entry     = bypass ? resp_entry : head;
    assign bus.out_valid = ~q_empty | bypass;
    assign bus.out_pc    = out_entry.pc;
    assign bus.out_inst  = out_entry.inst;
    assign bus.out_ex    = out_entry.ex;
    assign bus.out_ecode = out_entry.ecode;

    assign fetch_vaddr        = pc;
    assign bus.inst_sram_req  = req;
    assign bus.inst_sram_addr = xlat_paddr;

    // Counter invariants and tag FIFO consistency.
    assert property (@(posedge clk) disable iff (!rstn) (drop_cnt <= inflight) && (inflight <= CW'(MAX_OUT)));
    assert property (@(posedge clk) disable iff (!rstn) tag_count == (inflight - drop_cnt));
    assert property (@(posedge clk) disable iff (!rstn) !(fire && tag_full));
    assert property (@(posedge clk) disable iff (!rstn) !(resp_keep && tag_empty));

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed testbench for ifetch_queue (default build, no bypass).
`timescale 1ns/1ps
module tb_ifetch_queue;
    import fetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] fetch_vaddr;
    logic [31:0] xlat_paddr;
    logic        xlat_ex;
    logic [7:0]  xlat_ecode = 8'h00;
    logic        fault_en = 1'b0;
    logic [31:0] fault_addr = 32'h0;

    int checks = 0;
    int failures = 0;

    ifetch_queue_if bus();

    always #5 clk = ~clk;

    assign xlat_paddr = fetch_vaddr;
    assign xlat_ex    = fault_en && (fetch_vaddr == fault_addr);

    ifetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_vaddr    (fetch_vaddr),
        .xlat_paddr     (xlat_paddr),
        .xlat_ex        (xlat_ex),
        .xlat_ecode     (xlat_ecode),
        .bus            (bus)
    );

    // Memory model: accepts every request, answers in order, rdata = ~address.
    logic [31:0] mq[$];
    int          mq_n = 0;
    logic [31:0] mq_head = 32'h0;
    int          acc_cnt = 0;
    int          max_mq = 0;
    logic        hold = 1'b0;
    logic        m_fire;
    logic        m_dok;
    logic [31:0] m_addr;

    initial bus.inst_sram_addr_ok = 1'b1;
    initial bus.out_ready = 1'b1;

    always @(posedge clk) begin
        m_fire = bus.inst_sram_req && bus.inst_sram_addr_ok;
        m_dok  = bus.inst_sram_data_ok;
        m_addr = bus.inst_sram_addr;
        #1;
        if (!rstn) begin
            mq.delete();
            acc_cnt = 0;
            max_mq  = 0;
        end else begin
            if (m_dok && mq.size() > 0) void'(mq.pop_front());
            if (m_fire) begin
                mq.push_back(m_addr);
                acc_cnt++;
            end
        end
        mq_n    = mq.size();
        mq_head = (mq_n > 0) ? mq[0] : 32'h0;
        if (mq_n > max_mq) max_mq = mq_n;
    end

    always @* begin
        bus.inst_sram_data_ok = !hold && (mq_n > 0);
        bus.inst_sram_rdata   = ~mq_head;
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rstn = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        fault_en = 1'b0;
        hold = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (2) tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++;
        if (bus.inst_sram_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", bus.inst_sram_req); end
        checks++;
        if (fetch_vaddr !== RESET_PC) begin failures++; $display("FAIL reset_pc: got %h expected %h", fetch_vaddr, RESET_PC); end
    endtask

    task automatic test_streaming;
        logic [31:0] exp_pc;
        int n;
        bit first_dok;
        do_reset();
        exp_pc = RESET_PC;
        n = 0;
        first_dok = 0;
        for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
`ifndef IFQ_BYPASS_EN
            if (bus.inst_sram_data_ok && !first_dok) begin
                first_dok = 1;
                checks++;
                if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stream_latency: out_valid %b expected 0 in data_ok cycle", bus.out_valid); end
            end
`endif
            if (bus.out_valid) begin
                checks++;
                if (bus.out_pc !== exp_pc || bus.out_inst !== ~exp_pc || bus.out_ex !== 1'b0)
                    begin failures++; $display("FAIL stream_entry%0d: got pc %h inst %h ex %b expected pc %h inst %h ex 0", n, bus.out_pc, bus.out_inst, bus.out_ex, exp_pc, ~exp_pc); end
                exp_pc = exp_pc + 32'd4;
                n++;
            end
            tick();
        end
        checks++;
        if (n != 6) begin failures++; $display("FAIL stream_count: got %0d entries expected 6", n); end
        checks++;
        if (max_mq > MAX_OUT) begin failures++; $display("FAIL stream_max_inflight: got %0d expected <= %0d", max_mq, MAX_OUT); end
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_pc;
        int n;
        do_reset();
        bus.out_ready = 1'b0;
        repeat (12) tick();
        checks++;
        if (acc_cnt != DEPTH) begin failures++; $display("FAIL bp_accepted: got %0d expected %0d", acc_cnt, DEPTH); end
        checks++;
        if (bus.inst_sram_req !== 1'b0) begin failures++; $display("FAIL bp_req_stalled: got %b expected 0", bus.inst_sram_req); end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== RESET_PC) begin failures++; $display("FAIL bp_head: got valid %b pc %h expected valid 1 pc %h", bus.out_valid, bus.out_pc, RESET_PC); end
        bus.out_ready = 1'b1;
        exp_pc = RESET_PC;
        n = 0;
        for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
            #1;
            if (bus.out_valid) begin
                checks++;
                if (bus.out_pc !== exp_pc || bus.out_inst !== ~exp_pc)
                    begin failures++; $display("FAIL bp_drain%0d: got pc %h inst %h expected pc %h inst %h", n, bus.out_pc, bus.out_inst, exp_pc, ~exp_pc); end
                exp_pc = exp_pc + 32'd4;
                n++;
            end
            tick();
        end
        checks++;
        if (n != 4) begin failures++; $display("FAIL bp_drain_count: got %0d expected 4", n); end
    endtask

    task automatic test_redirect_drop;
        int cyc;
        do_reset();
        hold = 1'b1;
        repeat (2) tick();
        checks++;
        if (bus.inst_sram_req !== 1'b0 || mq_n != 2) begin failures++; $display("FAIL rd_two_inflight: got req %b outstanding %0d expected req 0 outstanding 2", bus.inst_sram_req, mq_n); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h1c00_1000;
        #1;
        checks++;
        if (bus.inst_sram_req !== 1'b0) begin failures++; $display("FAIL rd_no_req_in_redirect: got %b expected 0", bus.inst_sram_req); end
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (dut.drop_cnt !== 2'd2) begin failures++; $display("FAIL rd_drop_cnt: got %0d expected 2", dut.drop_cnt); end
        hold = 1'b0;
        for (cyc = 0; cyc < 20 && !bus.out_valid; cyc++) tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h1c00_1000 || bus.out_inst !== ~32'h1c00_1000)
            begin failures++; $display("FAIL rd_first_entry: got valid %b pc %h inst %h expected valid 1 pc 1c001000 inst %h", bus.out_valid, bus.out_pc, bus.out_inst, ~32'h1c00_1000); end
        checks++;
        if (dut.drop_cnt !== 2'd0) begin failures++; $display("FAIL rd_drop_done: got %0d expected 0", dut.drop_cnt); end
    endtask

    task automatic test_redirect_same_cycle;
        int cyc;
        do_reset();
        hold = 1'b1;
        repeat (2) tick();
        hold = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h1c00_2000;
        #1;
        checks++;
        if (bus.inst_sram_data_ok !== 1'b1 || mq_n != 2) begin failures++; $display("FAIL rs_setup: got data_ok %b outstanding %0d expected 1 and 2", bus.inst_sram_data_ok, mq_n); end
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (dut.drop_cnt !== 2'd1) begin failures++; $display("FAIL rs_drop_cnt: got %0d expected 1", dut.drop_cnt); end
        for (cyc = 0; cyc < 20 && !bus.out_valid; cyc++) tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h1c00_2000 || bus.out_ex !== 1'b0)
            begin failures++; $display("FAIL rs_first_entry: got valid %b pc %h ex %b expected valid 1 pc 1c002000 ex 0", bus.out_valid, bus.out_pc, bus.out_ex); end
    endtask

    task automatic test_adef;
        bit bad;
        rstn = 1'b0;
        hold = 1'b0;
        bus.out_ready = 1'b0;
        fault_en = 1'b1;
        fault_addr = 32'h1c00_0002;
        xlat_ecode = 8'h3f;
        redirect_valid = 1'b1;
        redirect_pc = 32'h1c00_0002;
        repeat (2) tick();
        rstn = 1'b1;
        #1;
        checks++;
        if (bus.inst_sram_req !== 1'b0) begin failures++; $display("FAIL adef_req_redirect: got %b expected 0", bus.inst_sram_req); end
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h1c00_0002 || bus.out_ex !== 1'b1 ||
            bus.out_ecode !== 8'h08 || bus.out_inst !== 32'h0)
            begin failures++; $display("FAIL adef_entry: got valid %b pc %h ex %b ecode %h inst %h expected 1 1c000002 1 08 00000000", bus.out_valid, bus.out_pc, bus.out_ex, bus.out_ecode, bus.out_inst); end
        checks++;
        if (acc_cnt != 0) begin failures++; $display("FAIL adef_no_request: got %0d accepted expected 0", acc_cnt); end
        bus.out_ready = 1'b1;
        tick();
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.out_valid !== 1'b0 || bus.inst_sram_req !== 1'b0) bad = 1;
            tick();
        end
        checks++;
        if (bad) begin failures++; $display("FAIL adef_halt: got activity in HALT expected out_valid 0 req 0"); end
        fault_en = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = RESET_PC;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (bus.inst_sram_req !== 1'b1 || fetch_vaddr !== RESET_PC) begin failures++; $display("FAIL adef_resume: got req %b pc %h expected req 1 pc %h", bus.inst_sram_req, fetch_vaddr, RESET_PC); end
    endtask

    task automatic test_xlat_fault;
        int n;
        do_reset();
        hold = 1'b1;
        fault_en = 1'b1;
        fault_addr = 32'h1c00_0004;
        xlat_ecode = 8'h3f;
        repeat (2) tick();
        checks++;
        if (bus.inst_sram_req !== 1'b0 || bus.out_valid !== 1'b0 || mq_n != 1)
            begin failures++; $display("FAIL xf_wait: got req %b valid %b outstanding %0d expected 0 0 1", bus.inst_sram_req, bus.out_valid, mq_n); end
        hold = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 20 && n < 2; cyc++) begin
            if (bus.out_valid) begin
                checks++;
                if (n == 0) begin
                    if (bus.out_pc !== RESET_PC || bus.out_inst !== ~RESET_PC || bus.out_ex !== 1'b0)
                        begin failures++; $display("FAIL xf_first: got pc %h inst %h ex %b expected pc %h inst %h ex 0", bus.out_pc, bus.out_inst, bus.out_ex, RESET_PC, ~RESET_PC); end
                end else begin
                    if (bus.out_pc !== 32'h1c00_0004 || bus.out_inst !== 32'h0 || bus.out_ex !== 1'b1 || bus.out_ecode !== 8'h3f)
                        begin failures++; $display("FAIL xf_exception: got pc %h inst %h ex %b ecode %h expected 1c000004 00000000 1 3f", bus.out_pc, bus.out_inst, bus.out_ex, bus.out_ecode); end
                end
                n++;
            end
            tick();
        end
        checks++;
        if (n != 2) begin failures++; $display("FAIL xf_count: got %0d entries expected 2", n); end
        fault_en = 1'b0;
    endtask

    task automatic test_async_reset;
        do_reset();
        repeat (5) tick();
        checks++;
        if (bus.out_valid !== 1'b1 || fetch_vaddr === RESET_PC) begin failures++; $display("FAIL ar_pre: got valid %b pc %h expected valid 1 and pc advanced", bus.out_valid, fetch_vaddr); end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || fetch_vaddr !== RESET_PC || bus.inst_sram_req !== 1'b0)
            begin failures++; $display("FAIL ar_immediate: got valid %b pc %h req %b expected 0 %h 0", bus.out_valid, fetch_vaddr, bus.inst_sram_req, RESET_PC); end
        repeat (2) tick();
        rstn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect_drop();
        test_redirect_same_cycle();
        test_adef();
        test_xlat_fault();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
